// File: rtl/bus_seq_arbiter.sv
// Two-requester arbiter that serialises 32-bit read/write transactions onto an
// 8-bit phased byte bus. Optional macro BUS_RR_ARB_EN selects round-robin arbitration.
module bus_seq_arbiter #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [7:0]  bus_out,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_oe,
    output logic [3:0]  bus_phase,
    output logic        busy
);

    // State encoding doubles as the externally visible phase code.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A0   = 4'd1,
        ST_A1   = 4'd2,
        ST_A2   = 4'd3,
        ST_A3   = 4'd4,
        ST_CMD  = 4'd5,
        ST_D0   = 4'd6,
        ST_D1   = 4'd7,
        ST_D2   = 4'd8,
        ST_D3   = 4'd9,
        ST_DONE = 4'd10,
        ST_GAP  = 4'd11
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t      state_r, state_s;
    logic        owner_r, owner_s;
    logic        we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [3:0]  gap_cnt_r, gap_cnt_s;
    logic [23:0] rd_buf_r;

    logic        grant_any_s;
    logic        grant_sel_s;

    logic [7:0]  bus_out_s;
    logic [7:0]  bus_oe_s;
    logic        busy_s;
    logic        done0_s;
    logic        done1_s;

`ifdef BUS_RR_ARB_EN
    logic        last_grant_r, last_grant_s;
`endif

    // Arbitration: pick a winner among the current requests.
    always_comb begin
        grant_any_s = req0 | req1;
        grant_sel_s = 1'b0;
        if (req0 && req1) begin
`ifdef BUS_RR_ARB_EN
            grant_sel_s = ~last_grant_r;
`else
            grant_sel_s = 1'b0;
`endif
        end else if (req1) begin
            grant_sel_s = 1'b1;
        end else begin
            grant_sel_s = 1'b0;
        end
    end

    // Next-state logic and transaction latching.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        we_s      = we_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    state_s = ST_A0;
                    owner_s = grant_sel_s;
                    we_s    = grant_sel_s ? we1    : we0;
                    addr_s  = grant_sel_s ? addr1  : addr0;
                    wdata_s = grant_sel_s ? wdata1 : wdata0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_A0:  state_s = ST_A1;
            ST_A1:  state_s = ST_A2;
            ST_A2:  state_s = ST_A3;
            ST_A3:  state_s = ST_CMD;
            ST_CMD: state_s = ST_D0;
            ST_D0:  state_s = ST_D1;
            ST_D1:  state_s = ST_D2;
            ST_D2:  state_s = ST_D3;
            ST_D3:  state_s = ST_DONE;
            ST_DONE: begin
                if (GAP_CYCLES > 0) begin
                    state_s   = ST_GAP;
                    gap_cnt_s = GAP_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

`ifdef BUS_RR_ARB_EN
    // Round-robin pointer follows every grant.
    always_comb begin
        if ((state_r == ST_IDLE) && grant_any_s) begin
            last_grant_s = grant_sel_s;
        end else begin
            last_grant_s = last_grant_r;
        end
    end
`endif

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        bus_out_s = 8'h00;
        bus_oe_s  = 8'h00;
        busy_s    = (state_s != ST_IDLE);
        done0_s   = 1'b0;
        done1_s   = 1'b0;
        case (state_s)
            ST_A0:  begin bus_out_s = addr_s[7:0];   bus_oe_s = 8'hFF; end
            ST_A1:  begin bus_out_s = addr_s[15:8];  bus_oe_s = 8'hFF; end
            ST_A2:  begin bus_out_s = addr_s[23:16]; bus_oe_s = 8'hFF; end
            ST_A3:  begin bus_out_s = addr_s[31:24]; bus_oe_s = 8'hFF; end
            ST_CMD: begin bus_out_s = {7'b0000000, we_s}; bus_oe_s = 8'hFF; end
            ST_D0, ST_D1, ST_D2, ST_D3: begin
                if (we_s) begin
                    bus_oe_s = 8'hFF;
                    case (state_s)
                        ST_D0:   bus_out_s = wdata_s[7:0];
                        ST_D1:   bus_out_s = wdata_s[15:8];
                        ST_D2:   bus_out_s = wdata_s[23:16];
                        default: bus_out_s = wdata_s[31:24];
                    endcase
                end else begin
                    bus_oe_s  = 8'h00;
                    bus_out_s = 8'h00;
                end
            end
            ST_DONE: begin
                done0_s = ~owner_s;
                done1_s = owner_s;
            end
            default: begin
                bus_out_s = 8'h00;
                bus_oe_s  = 8'h00;
            end
        endcase
    end

    // Control state, latched transaction and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            owner_r   <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            gap_cnt_r <= 4'd0;
            bus_out   <= 8'h00;
            bus_oe    <= 8'h00;
            bus_phase <= 4'd0;
            busy      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            gap_cnt_r <= gap_cnt_s;
            bus_out   <= bus_out_s;
            bus_oe    <= bus_oe_s;
            bus_phase <= state_s;
            busy      <= busy_s;
            done0     <= done0_s;
            done1     <= done1_s;
        end
    end

`ifdef BUS_RR_ARB_EN
    // Last-grant pointer; after reset requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_s;
        end
    end
`endif

    // Read capture: bytes gathered in a shadow buffer, published on entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_buf_r <= 24'h00_0000;
            rdata0   <= 32'h0000_0000;
            rdata1   <= 32'h0000_0000;
        end else if (!we_r) begin
            case (state_r)
                ST_D0: rd_buf_r[7:0]   <= bus_in;
                ST_D1: rd_buf_r[15:8]  <= bus_in;
                ST_D2: rd_buf_r[23:16] <= bus_in;
                ST_D3: begin
                    if (owner_r) begin
                        rdata1 <= {bus_in, rd_buf_r};
                    end else begin
                        rdata0 <= {bus_in, rd_buf_r};
                    end
                end
                default: rd_buf_r <= rd_buf_r;
            endcase
        end else begin
            rd_buf_r <= rd_buf_r;
        end
    end

endmodule

// File: tb/tb_bus_seq_arbiter.sv
// Scoreboard bench for bus_seq_arbiter: stimulus pushes expected bus beats and
// completions; independent monitors pop and compare. A second instance covers GAP_CYCLES=3.
module tb_bus_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
    logic        done0, done1, busy;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  bus_out, bus_oe;
    logic [7:0]  bus_in = 8'h00;
    logic [3:0]  bus_phase;

    logic        g_req0 = 1'b0;
    logic        g_done0, g_done1, g_busy;
    logic [31:0] g_rdata0, g_rdata1;
    logic [7:0]  g_bus_out, g_bus_oe;
    logic [3:0]  g_phase;

    always #5 clk = ~clk;

    bus_seq_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .bus_out(bus_out), .bus_in(bus_in), .bus_oe(bus_oe),
        .bus_phase(bus_phase), .busy(busy)
    );

    bus_seq_arbiter #(.GAP_CYCLES(3)) dut_gap (
        .clk(clk), .rst(rst), .req0(g_req0), .req1(1'b0), .we0(1'b1), .we1(1'b0),
        .addr0(32'h0000_0040), .addr1(32'h0), .wdata0(32'h5555_AAAA), .wdata1(32'h0),
        .done0(g_done0), .done1(g_done1), .rdata0(g_rdata0), .rdata1(g_rdata1),
        .bus_out(g_bus_out), .bus_in(8'h00), .bus_oe(g_bus_oe),
        .bus_phase(g_phase), .busy(g_busy)
    );

    typedef struct {logic [3:0] phase; logic [7:0] data; logic [7:0] oe;} beat_t;
    typedef struct {logic owner; int cyc; logic [31:0] rd0; logic [31:0] rd1;} done_t;

    beat_t       beat_q[$];
    done_t       done_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          beat_en = 1'b1;
    logic [31:0] rd_pat = 32'h0;
    bit          g_run = 1'b0;
    int          g_ndone = 0;
    int          g_last = -1;
    int          g_first_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
    endtask

    task automatic push_beats(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.phase = 4'(k + 1); b.data = addr[8*k +: 8]; b.oe = 8'hFF;
            beat_q.push_back(b);
        end
        b.phase = 4'd5; b.data = {7'b0000000, we}; b.oe = 8'hFF;
        beat_q.push_back(b);
        for (int k = 0; k < 4; k++) begin
            b.phase = 4'(k + 6);
            b.data  = we ? wdata[8*k +: 8] : 8'h00;
            b.oe    = we ? 8'hFF : 8'h00;
            beat_q.push_back(b);
        end
    endtask

    task automatic wait_done(input int n);
        int seen = 0;
        for (int i = 0; i < 40 * n && seen < n; i++) begin
            @(negedge clk);
            if (done0 || done1) seen++;
        end
        if (seen < n) fail_now("done_timeout");
    endtask

    task automatic run_txn(input logic who, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clk);
        if (who) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else     begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        push_beats(we, addr, wdata);
        done_q.push_back('{who, cyc + 10, e0, e1});
        wait_done(1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic contend(input int n, input logic [31:0] e0, input logic [31:0] e1);
        logic own;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0100; wdata0 = 32'h0102_0304;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0200; wdata1 = 32'h0A0B_0C0D;
        for (int i = 0; i < n; i++) begin
`ifdef BUS_RR_ARB_EN
            own = i[0];
`else
            own = 1'b0;
`endif
            push_beats(1'b1, own ? addr1 : addr0, own ? wdata1 : wdata0);
            done_q.push_back('{own, cyc + 10 + 11 * i, e0, e1});
        end
        wait_done(n);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Bus responder: return read-pattern bytes while in D0-D3.
    initial forever begin
        @(negedge clk);
        case (bus_phase)
            4'd6:    bus_in = rd_pat[7:0];
            4'd7:    bus_in = rd_pat[15:8];
            4'd8:    bus_in = rd_pat[23:16];
            4'd9:    bus_in = rd_pat[31:24];
            default: bus_in = 8'h00;
        endcase
    end

    // Main monitor: bus beats and completions against the scoreboard.
    initial forever begin
        beat_t b;
        done_t d;
        @(negedge clk);
        if (!rst) begin
            if (beat_en && bus_phase >= 4'd1 && bus_phase <= 4'd9) begin
                if (beat_q.size() == 0) fail_now("beat_unexpected");
                else begin
                    b = beat_q.pop_front();
                    check("beat_phase", 32'(bus_phase), 32'(b.phase));
                    check("beat_data", 32'(bus_out), 32'(b.data));
                    check("beat_oe", 32'(bus_oe), 32'(b.oe));
                    check("beat_busy", 32'(busy), 32'd1);
                end
            end
            if (done0 || done1) begin
                if (done_q.size() == 0) fail_now("done_unexpected");
                else begin
                    d = done_q.pop_front();
                    check("done_owner", 32'({done1, done0}), d.owner ? 32'd2 : 32'd1);
                    check("done_cycle", 32'(cyc), 32'(d.cyc));
                    check("done_rdata0", rdata0, d.rd0);
                    check("done_rdata1", rdata1, d.rd1);
                end
            end
        end
    end

    // Gap-instance monitor: period and busy during GAP.
    initial forever begin
        @(negedge clk);
        if (!rst && g_run) begin
            if (g_phase == 4'd11) check("gap_busy", 32'(g_busy), 32'd1);
            if (g_done1) fail_now("gap_done1");
            if (g_done0) begin
                g_ndone++;
                if (g_last >= 0) check("gap_period", 32'(cyc - g_last), 32'd14);
                else check("gap_first_done", 32'(cyc), 32'(g_first_exp));
                g_last = cyc;
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_bus_out"}, 32'(bus_out), 32'd0);
        check({tag, "_bus_oe"}, 32'(bus_oe), 32'd0);
        check({tag, "_phase"}, 32'(bus_phase), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'({done1, done0}), 32'd0);
        check({tag, "_rdata0"}, rdata0, 32'd0);
        check({tag, "_rdata1"}, rdata1, 32'd0);
    endtask

    initial begin
        bit hit;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        rd_pat = 32'hDDCC_BBAA;
        run_txn(1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'hDDCC_BBAA, 32'h0);
        run_txn(1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'hDDCC_BBAA, 32'h0);
        rd_pat = 32'h4433_2211;
        run_txn(1'b1, 1'b0, 32'hA5A5_0001, 32'h0, 32'hDDCC_BBAA, 32'h4433_2211);
        contend(4, 32'hDDCC_BBAA, 32'h4433_2211);

        // Reset in the middle of a read: no completion may follow.
        beat_en = 1'b0;
        rd_pat = 32'h1111_1111;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'hDEAD_0000;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (bus_phase == 4'd7) hit = 1'b1;
        end
        if (!hit) fail_now("reach_d1");
        rst = 1'b1;
        #1 check_zero_outputs("midreset");
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        beat_en = 1'b1;

        contend(2, 32'h0, 32'h0);
        rd_pat = 32'h8765_4321;
        run_txn(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h8765_4321, 32'h0);

        // Continuous requests into the GAP_CYCLES=3 instance.
        @(negedge clk);
        g_run = 1'b1;
        g_req0 = 1'b1;
        g_first_exp = cyc + 10;
        for (int i = 0; i < 120 && g_ndone < 4; i++) @(negedge clk);
        g_req0 = 1'b0;
        check("gap_done_count", 32'(g_ndone), 32'd4);

        repeat (20) @(negedge clk);
        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_seq_arbiter.md
BUS_SEQ_ARBITER -- requirements
Module: bus_seq_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0, meaning forced idle cycles after each transaction, legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1  transaction request from requester 0/1.
REQ-005 SHALL have ports we0/we1  input  1  request type: 1=write, 0=read.
REQ-006 SHALL have ports addr0/addr1  input  32  request address.
REQ-007 SHALL have ports wdata0/wdata1  input  32  write data.
REQ-008 SHALL have ports done0/done1  output  1  one-cycle completion pulse to the owning requester.
REQ-009 SHALL have ports rdata0/rdata1  output  32  read result, valid while doneN=1 and held until that requester's next read completes.
REQ-010 SHALL have ports bus_out  output  8, bus_in  input  8, bus_oe  output  8  for the serialized external byte bus.
REQ-011 SHALL have ports bus_phase  output  4  current phase code, and busy  output  1  high in any non-IDLE state.

Function
REQ-012 SHALL implement states IDLE, A0-A3, CMD, D0-D3, DONE, GAP; bus_phase = 0 for IDLE, 1-4 for A0-A3, 5 for CMD, 6-9 for D0-D3, 10 for DONE, 11 for GAP.
REQ-013 SHALL sample requests only in IDLE; on a grant, latch owner, we, addr and wdata, and enter A0 on the next edge.
REQ-014 SHALL drive bus_out = latched addr byte k in Ak, LSB first, with bus_oe = 8'hFF.
REQ-015 SHALL drive bus_out = {7'b0, we} in CMD, with bus_oe = 8'hFF.
REQ-016 On a write, SHALL drive bus_out = wdata byte k in Dk, LSB first, with bus_oe = 8'hFF.
REQ-017 On a read, SHALL drive bus_oe = 8'h00 and bus_out = 8'h00 in Dk, and capture bus_in into rdata byte k at the edge leaving Dk.
REQ-018 SHALL assert the owner's doneN for exactly the DONE cycle; a request sampled at edge k yields DONE during cycle k+10.
REQ-019 SHALL go from DONE to GAP when GAP_CYCLES > 0, staying GAP_CYCLES cycles, otherwise to IDLE; back-to-back period is 11 + GAP_CYCLES cycles.
REQ-020 SHALL always complete a granted transaction even if its reqN drops mid-transaction; doneN still pulses.
REQ-021 Requesters SHALL hold reqN until doneN; a reqN still high in the cycle after doneN is treated as a new request.
REQ-022 SHALL leave rdataN unchanged on write transactions and on transactions owned by the other requester.
REQ-023 SHALL register all outputs and have no combinational path from any input to any output.

Reset
REQ-024 While rst=1, SHALL force state IDLE, bus_out=0, bus_oe=0, bus_phase=0, busy=0, done0/done1=0, rdata0/rdata1=0, and last-grant pointer=1.
REQ-025 Reset mid-transaction SHALL abort the transaction with no doneN pulse; arbitration resumes on the first edge after rst falls.

Configuration
REQ-026 With macro BUS_RR_ARB_EN defined, simultaneous requests SHALL be granted to the requester not granted last (round-robin), and the pointer SHALL update on each grant.
REQ-027 Without BUS_RR_ARB_EN, req0 SHALL always win simultaneous requests (fixed priority), and the pointer logic SHALL be absent.
REQ-028 With either setting, a lone request SHALL be granted in the first IDLE cycle.

Verification
REQ-029 Read: req0=1, we0=0, addr0=32'h12345678, bus_in=8'hAA,BB,CC,DD during D0-D3 -> bus_out 78,56,34,12,01? no: 78,56,34,12 then 00 in CMD; done0 at cycle 10; rdata0=32'hDDCCBBAA.
REQ-030 Write: req1=1, we1=1, addr1=0, wdata1=32'hCAFEF00D -> CMD bus_out=01; D0-D3 bus_out=0D,F0,FE,CA with bus_oe=FF; done1 pulse; rdata1 unchanged.
REQ-031 Contention: req0 and req1 held high, BUS_RR_ARB_EN defined -> grants alternate 0,1,0,1; without the macro -> four consecutive grants to 0, none to 1.
REQ-032 Reset mid-transaction: rst asserted during D1 of a read -> outputs zero immediately, no doneN pulse; a new request after release completes normally.
REQ-033 Gap: GAP_CYCLES=3, continuous req0 -> done0 pulses every 14 cycles; busy stays high through GAP.
